operand_fetch: RTL and testbench

Decode-side operand fetch stage for the RISC-V core. It accepts one instruction at a time over a valid/ready handshake and drives the rs1/rs2 fields to the synchronous-read register file. It returns the instruction one cycle later with both source operands resolved, including x0 forcing and write-back bypass. It sits between the fetch/decode buffer and the execute stage, and it shares the register file's write port signals so it can forward in-flight write-back data.

---
 rtl/operand_fetch.sv | 152 +++++++++++++++
 tb/tb_operand_fetch.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Operand fetch stage: accepts one instruction, reads the synchronous register file,
// and presents the instruction a cycle later with x0-forced, write-back-bypassed operands.
module operand_fetch #(
   parameter int ADW = 5,
   parameter int DPW = 32,
   parameter int ILW = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [ILW-1:0] in_instr,
   input  logic [DPW-1:0] in_pc,
   output logic [ADW-1:0] rf_addr_1,
   output logic [ADW-1:0] rf_addr_2,
   input  logic [DPW-1:0] rf_rd_1,
   input  logic [DPW-1:0] rf_rd_2,
   input  logic           wb_we,
   input  logic [ADW-1:0] wb_addr,
   input  logic [DPW-1:0] wb_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [ILW-1:0] out_instr,
   output logic [DPW-1:0] out_pc,
   output logic [ADW-1:0] out_rd,
   output logic [DPW-1:0] out_rs1_val,
   output logic [DPW-1:0] out_rs2_val
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FRESH = 2'd1,
      HELD  = 2'd2
   } state_t;

   state_t         state_r;
   state_t         state_next_s;
   logic [ILW-1:0] instr_r;
   logic [DPW-1:0] pc_r;
   logic           byp1_hit_r;
   logic           byp2_hit_r;
   logic [DPW-1:0] byp1_data_r;
   logic [DPW-1:0] byp2_data_r;
   logic [DPW-1:0] hold1_r;
   logic [DPW-1:0] hold2_r;
   logic [DPW-1:0] base1_s;
   logic [DPW-1:0] base2_s;
   logic [ADW-1:0] rs1_s;
   logic [ADW-1:0] rs2_s;
   logic           accept_s;
   logic           hold_en_s;

   // x0 reads as zero; a same-cycle write-back wins over the base operand.
   function automatic logic [DPW-1:0] resolve(
      input logic [ADW-1:0] rs,
      input logic [DPW-1:0] base,
      input logic           we,
      input logic [ADW-1:0] waddr,
      input logic [DPW-1:0] wdata
   );
      if (rs == {ADW{1'b0}}) begin
         return {DPW{1'b0}};
      end else if (we && (waddr == rs)) begin
         return wdata;
      end else begin
         return base;
      end
   endfunction

   assign rf_addr_1 = in_instr[19:15];
   assign rf_addr_2 = in_instr[24:20];
   assign rs1_s     = instr_r[19:15];
   assign rs2_s     = instr_r[24:20];
   assign out_valid = (state_r != IDLE);
   assign out_instr = instr_r;
   assign out_pc    = pc_r;
   assign out_rd    = instr_r[11:7];
   assign in_ready  = !flush && ((state_r == IDLE) || out_ready);
   assign accept_s  = in_valid && in_ready;
   assign hold_en_s = (state_r != IDLE) && !out_ready && !flush;

   // Next-state selection; flush overrides every other transition.
   always_comb begin
      state_next_s = state_r;
      if (flush) begin
         state_next_s = IDLE;
      end else if (accept_s) begin
         state_next_s = FRESH;
      end else if ((state_r != IDLE) && out_ready) begin
         state_next_s = IDLE;
      end else if (state_r == FRESH) begin
         state_next_s = HELD;
      end else begin
         state_next_s = state_r;
      end
   end

   // Base operand: register file (or its same-edge bypass) when fresh, hold registers when stalled.
   always_comb begin
      base1_s = hold1_r;
      base2_s = hold2_r;
      case (state_r)
         FRESH: begin
            base1_s = byp1_hit_r ? byp1_data_r : rf_rd_1;
            base2_s = byp2_hit_r ? byp2_data_r : rf_rd_2;
         end
         HELD: begin
            base1_s = hold1_r;
            base2_s = hold2_r;
         end
         default: begin
            base1_s = hold1_r;
            base2_s = hold2_r;
         end
      endcase
   end

   assign out_rs1_val = resolve(rs1_s, base1_s, wb_we, wb_addr, wb_data);
   assign out_rs2_val = resolve(rs2_s, base2_s, wb_we, wb_addr, wb_data);

   // State, held instruction, same-edge bypass capture and stall hold registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         instr_r     <= {ILW{1'b0}};
         pc_r        <= {DPW{1'b0}};
         byp1_hit_r  <= 1'b0;
         byp2_hit_r  <= 1'b0;
         byp1_data_r <= {DPW{1'b0}};
         byp2_data_r <= {DPW{1'b0}};
         hold1_r     <= {DPW{1'b0}};
         hold2_r     <= {DPW{1'b0}};
      end else begin
         state_r <= state_next_s;
         if (accept_s) begin
            instr_r     <= in_instr;
            pc_r        <= in_pc;
            byp1_hit_r  <= wb_we && (wb_addr == in_instr[19:15]);
            byp2_hit_r  <= wb_we && (wb_addr == in_instr[24:20]);
            byp1_data_r <= wb_data;
            byp2_data_r <= wb_data;
         end
         // Capturing the forwarded value also folds in any matching write this cycle.
         if (hold_en_s) begin
            hold1_r <= out_rs1_val;
            hold2_r <= out_rs2_val;
         end
      end
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch with a synchronous-read register file model.
module tb_operand_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic [4:0]  rf_addr_1;
   logic [4:0]  rf_addr_2;
   logic [31:0] rf_rd_1;
   logic [31:0] rf_rd_2;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [4:0]  out_rd;
   logic [31:0] out_rs1_val;
   logic [31:0] out_rs2_val;

   logic [31:0] regs [32];
   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [31:0] ADD_X7_X5_X6 = 32'h006283B3;
   localparam logic [31:0] ADD_X1_X0_X5 = 32'h005000B3;

   operand_fetch dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .rf_addr_1(rf_addr_1), .rf_addr_2(rf_addr_2), .rf_rd_1(rf_rd_1), .rf_rd_2(rf_rd_2),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
      .out_rd(out_rd), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val)
   );

   always #5 clk = ~clk;

   // Register file: reads return the pre-write value on a same-edge write.
   always @(posedge clk) begin
      rf_rd_1 <= regs[rf_addr_1];
      rf_rd_2 <= regs[rf_addr_2];
      if (wb_we) regs[wb_addr] <= wb_data;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      wb_we = 1'b1; wb_addr = a; wb_data = d;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 32'h0;
      rf_rd_1 = 32'h0; rf_rd_2 = 32'h0;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = ADD_X7_X5_X6; in_pc = 32'h0;
      wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'h0; out_ready = 1'b1;
      #1;
      check_eq("reset_valid", {31'h0, out_valid}, 32'h0);
      check_eq("reset_pc", out_pc, 32'h0);
      check_eq("reset_instr", out_instr, 32'h0);
      check_eq("reset_rd", {27'h0, out_rd}, 32'h0);
      check_eq("reset_in_ready", {31'h0, in_ready}, 32'h1);
      @(negedge clk);
      rst = 1'b0;

      // Preload x5, x6, and x0 (the model lets x0 hold garbage).
      wb_write(5'd5, 32'h11);
      wb_write(5'd6, 32'h22);
      wb_write(5'd0, 32'hDEAD);

      // Basic add x7,x5,x6.
      @(negedge clk);
      wb_we = 1'b0; in_valid = 1'b1; in_instr = ADD_X7_X5_X6; in_pc = 32'h100;
      #1;
      check_eq("basic_addr1", {27'h0, rf_addr_1}, 32'd5);
      check_eq("basic_addr2", {27'h0, rf_addr_2}, 32'd6);
      check_eq("basic_in_ready", {31'h0, in_ready}, 32'h1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check_eq("basic_valid", {31'h0, out_valid}, 32'h1);
      check_eq("basic_rs1", out_rs1_val, 32'h11);
      check_eq("basic_rs2", out_rs2_val, 32'h22);
      check_eq("basic_rd", {27'h0, out_rd}, 32'd7);
      check_eq("basic_pc", out_pc, 32'h100);
      @(negedge clk);
      #1;
      check_eq("basic_drain", {31'h0, out_valid}, 32'h0);

      // Same-edge write of x5 at the accept edge, then a stall of 3 cycles.
      @(negedge clk);
      in_valid = 1'b1; in_pc = 32'h104; wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hAA;
      @(negedge clk);
      in_valid = 1'b0; wb_we = 1'b0; out_ready = 1'b0;
      #1;
      check_eq("bypass_rs1", out_rs1_val, 32'hAA);
      check_eq("stall1_rs2", out_rs2_val, 32'h22);
      @(negedge clk);
      wb_we = 1'b1; wb_addr = 5'd6; wb_data = 32'h55;
      #1;
      check_eq("stall2_rs2", out_rs2_val, 32'h55);
      check_eq("stall2_rs1", out_rs1_val, 32'hAA);
      check_eq("stall2_pc", out_pc, 32'h104);
      @(negedge clk);
      wb_we = 1'b0;
      #1;
      check_eq("stall3_rs2", out_rs2_val, 32'h55);
      check_eq("stall3_rs1", out_rs1_val, 32'hAA);
      check_eq("stall3_pc", out_pc, 32'h104);
      check_eq("stall3_rd", {27'h0, out_rd}, 32'd7);
      check_eq("stall3_in_ready", {31'h0, in_ready}, 32'h0);
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      check_eq("stall_xfer_valid", {31'h0, out_valid}, 32'h1);
      check_eq("stall_xfer_rs2", out_rs2_val, 32'h55);
      @(negedge clk);
      #1;
      check_eq("stall_drain", {31'h0, out_valid}, 32'h0);

      // x0 source: rf holds 0xDEAD, wb writes x0=0xBEEF on accept and next cycle.
      @(negedge clk);
      in_valid = 1'b1; in_instr = ADD_X1_X0_X5; in_pc = 32'h180;
      wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hBEEF;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check_eq("x0_rs1", out_rs1_val, 32'h0);
      check_eq("x0_rs2", out_rs2_val, 32'hAA);
      check_eq("x0_rd", {27'h0, out_rd}, 32'd1);
      @(negedge clk);
      wb_we = 1'b0;

      // Back-to-back: four instructions, no bubbles.
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         in_valid = (k < 4);
         in_instr = ADD_X7_X5_X6;
         in_pc = 32'h100 + 32'(4 * k);
         #1;
         if (k > 0) begin
            check_eq($sformatf("b2b_valid%0d", k - 1), {31'h0, out_valid}, 32'h1);
            check_eq($sformatf("b2b_pc%0d", k - 1), out_pc, 32'h100 + 32'(4 * (k - 1)));
            check_eq($sformatf("b2b_rs1_%0d", k - 1), out_rs1_val, 32'hAA);
            check_eq($sformatf("b2b_rs2_%0d", k - 1), out_rs2_val, 32'h55);
         end
      end
      @(negedge clk);
      #1;
      check_eq("b2b_drain", {31'h0, out_valid}, 32'h0);

      // Flush while HELD with a pending input.
      @(negedge clk);
      in_valid = 1'b1; in_pc = 32'h200;
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      #1;
      check_eq("flush_pre_valid", {31'h0, out_valid}, 32'h1);
      flush = 1'b1; in_valid = 1'b1; in_pc = 32'h204;
      #1;
      check_eq("flush_in_ready", {31'h0, in_ready}, 32'h0);
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #1;
      check_eq("flush_valid", {31'h0, out_valid}, 32'h0);
      check_eq("flush_no_accept_pc", out_pc, 32'h200);

      // Asynchronous reset mid-FRESH.
      @(negedge clk);
      in_valid = 1'b1; in_pc = 32'h300;
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      check_eq("rst_pre_valid", {31'h0, out_valid}, 32'h1);
      #1;
      rst = 1'b1;
      #1;
      check_eq("rst_valid", {31'h0, out_valid}, 32'h0);
      check_eq("rst_pc", out_pc, 32'h0);
      check_eq("rst_instr", out_instr, 32'h0);
      check_eq("rst_addr1", {27'h0, rf_addr_1}, 32'd5);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("post_rst_valid", {31'h0, out_valid}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
